// File: rtl/mem_access_pkg.sv
// Shared types and op-class helpers for the MEM-stage access unit.
// Contents: mop_t op codes, state_t FSM encoding, is_load/is_store/is_subword.
// Combinational helpers only; no timing or backpressure of their own.
package mem_access_pkg;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LW   = 4'd1,
    MOP_LH   = 4'd2,
    MOP_LHU  = 4'd3,
    MOP_LB   = 4'd4,
    MOP_LBU  = 4'd5,
    MOP_SW   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SB   = 4'd8
  } mop_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MOP_LW) && (op <= MOP_LBU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MOP_SW) && (op <= MOP_SB);
  endfunction

  // Halfword and byte accesses; for stores these need a read-modify-write.
  function automatic logic is_subword(input logic [3:0] op);
    return (op == MOP_LH) || (op == MOP_LHU) || (op == MOP_LB) ||
           (op == MOP_LBU) || (op == MOP_SH) || (op == MOP_SB);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle between EX/MEM register, data memory and MEM/WB register.
// Ports: ex_* request from EX/MEM, mem_* memory side, wb_* retirement, stall upstream.
// slave = access unit; master = pipeline/memory side driving ex_* and mem_rd.
interface mem_access_unit_if #(parameter int ADDR_W = 6);
  logic              ex_valid;
  logic [3:0]        ex_op;
  logic [31:0]       ex_addr;
  logic [31:0]       ex_wdata;
  logic [4:0]        ex_rd;
  logic              ex_regwrite;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic              mem_write;
  logic              mem_read;
  logic [31:0]       mem_rd;
  logic              wb_valid;
  logic [31:0]       wb_data;
  logic [4:0]        wb_rd;
  logic              wb_regwrite;
  logic              wb_exc;

  modport slave (
    input  ex_valid, ex_op, ex_addr, ex_wdata, ex_rd, ex_regwrite, mem_rd,
    output stall, mem_addr, mem_wd, mem_write, mem_read,
    output wb_valid, wb_data, wb_rd, wb_regwrite, wb_exc
  );

  modport master (
    output ex_valid, ex_op, ex_addr, ex_wdata, ex_rd, ex_regwrite, mem_rd,
    input  stall, mem_addr, mem_wd, mem_write, mem_read,
    input  wb_valid, wb_data, wb_rd, wb_regwrite, wb_exc
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: load extract/extend and store lane merge (little endian).
// Ports: op, byte_off, rd_word (memory word), base (merge word), wdata -> load_data, store_data.
// Purely combinational, zero latency, no backpressure.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] base,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    lb = 8'd0;
    case (byte_off)
      2'd0: lb = rd_word[7:0];
      2'd1: lb = rd_word[15:8];
      2'd2: lb = rd_word[23:16];
      2'd3: lb = rd_word[31:24];
      default: lb = 8'd0;
    endcase
    lh = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_data = rd_word;
    case (op)
      MOP_LH:  load_data = {{16{lh[15]}}, lh};
      MOP_LHU: load_data = {16'd0, lh};
      MOP_LB:  load_data = {{24{lb[7]}}, lb};
      MOP_LBU: load_data = {24'd0, lb};
      default: load_data = rd_word;
    endcase
  end

  // SB/SH overwrite only their lanes of the captured word; SW takes wdata whole.
  always_comb begin
    store_data = base;
    case (op)
      MOP_SB: begin
        case (byte_off)
          2'd0: store_data[7:0]   = wdata[7:0];
          2'd1: store_data[15:8]  = wdata[7:0];
          2'd2: store_data[23:16] = wdata[7:0];
          2'd3: store_data[31:24] = wdata[7:0];
          default: store_data = base;
        endcase
      end
      MOP_SH: begin
        if (byte_off[1]) store_data[31:16] = wdata[15:0];
        else             store_data[15:0]  = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: word addressing, load extension, SB/SH read-modify-write, exceptions.
// Ports: clk, rst (async high), bus (slave modport: ex_* in, mem_* to memory, wb_* MEM/WB out, stall).
// Latency 1 cycle; SB/SH take 2 cycles and raise stall during the read cycle.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_access_unit_if.slave bus
);

  logic [3:0]        op;
  state_t            state_q, state_d;
  logic              known, ld, st, misalign, range_err, exc, rmw_start;
  logic [DATA_W-1:0] rmw_q;
  logic [31:0]       load_data, store_data;
  logic              stall_c, mem_read_c, mem_write_c;

  assign op    = bus.ex_op;
  assign known = (op <= MOP_SB);
  assign ld    = is_load(op);
  assign st    = is_store(op);

  always_comb begin
    misalign = 1'b0;
    case (op)
      MOP_LW, MOP_SW:          misalign = |bus.ex_addr[1:0];
      MOP_LH, MOP_LHU, MOP_SH: misalign = bus.ex_addr[0];
      default:                 misalign = 1'b0;
    endcase
  end

  // Any address bit above the memory's span is out of range.
  assign range_err = |bus.ex_addr[31:ADDR_W+2];
  assign exc       = bus.ex_valid && (!known || ((ld || st) && (misalign || range_err)));
  assign rmw_start = bus.ex_valid && !exc && st && is_subword(op);

  mem_lane_align u_align (
    .op         (op),
    .byte_off   (bus.ex_addr[1:0]),
    .rd_word    (bus.mem_rd),
    .base       (rmw_q),
    .wdata      (bus.ex_wdata),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rmw_start) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Gated by rst so an abort mid-RMW silences the memory and stall at once.
  always_comb begin
    stall_c     = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.ex_valid && !exc) begin
            stall_c     = rmw_start;
            mem_read_c  = ld || rmw_start;
            mem_write_c = (op == MOP_SW);
          end
        end
        ST_WRITE: mem_write_c = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.stall     = stall_c;
  assign bus.mem_read  = mem_read_c;
  assign bus.mem_write = mem_write_c;
  assign bus.mem_addr  = bus.ex_addr[ADDR_W+1:2];
  // In WRITE the op is SB/SH so this is the merged word; in IDLE only SW writes.
  assign bus.mem_wd    = store_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rmw_q <= '0;
    else if (state_q == ST_IDLE && rmw_start) rmw_q <= bus.mem_rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_valid    <= 1'b0;
      bus.wb_data     <= 32'd0;
      bus.wb_rd       <= 5'd0;
      bus.wb_regwrite <= 1'b0;
      bus.wb_exc      <= 1'b0;
    end else if (state_q == ST_WRITE) begin
      bus.wb_valid    <= 1'b1;
      bus.wb_data     <= bus.ex_addr;
      bus.wb_rd       <= bus.ex_rd;
      bus.wb_regwrite <= 1'b0;
      bus.wb_exc      <= 1'b0;
    end else if (!bus.ex_valid || rmw_start) begin
      bus.wb_valid    <= 1'b0;
    end else begin
      bus.wb_valid    <= 1'b1;
      bus.wb_rd       <= bus.ex_rd;
      bus.wb_exc      <= exc;
      bus.wb_regwrite <= !exc && !st && bus.ex_regwrite;
      bus.wb_data     <= (ld && !exc) ? load_data : bus.ex_addr;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against an array-based reference memory.
// Ports: none; owns clock, reset, the interface instance and a 64-word behavioural data memory.
// Each op is driven after a rising edge and held until it retires.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst;
  logic load_mem;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(AW)) bus ();

  mem_access_unit #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] dmem [64];
  always @(posedge clk) begin
    if (load_mem) for (int i = 0; i < 64; i++) dmem[i] <= 32'(i);
    else if (bus.mem_write) dmem[bus.mem_addr] <= bus.mem_wd;
  end
  assign bus.mem_rd = dmem[bus.mem_addr];

  logic [31:0] ref_mem [64];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drives one op at posedge+2 and checks it through retirement against the model.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic rw, input logic vld);
    logic        known, isld, isst, exc, st_e, rd_e, wr_e;
    int unsigned off, widx, sh;
    logic [31:0] word, newword, lv, mask;
    known = (op <= 4'd8);
    isld  = (op >= 4'd1) && (op <= 4'd5);
    isst  = (op >= 4'd6) && (op <= 4'd8);
    off   = addr % 4;
    widx  = (addr / 4) % 64;
    sh    = 8 * off;
    exc   = !known || ((isld || isst) && ((addr >= 32'd256) ||
            ((op == MOP_LW || op == MOP_SW) && off != 0) ||
            ((op == MOP_LH || op == MOP_LHU || op == MOP_SH) && (off % 2) != 0)));
    st_e  = vld && !exc && (op == MOP_SH || op == MOP_SB);
    rd_e  = vld && !exc && (isld || st_e);
    wr_e  = vld && !exc && (op == MOP_SW);

    bus.ex_valid = vld; bus.ex_op = op; bus.ex_addr = addr;
    bus.ex_wdata = wdata; bus.ex_rd = rd; bus.ex_regwrite = rw;
    #1;
    check("mem_addr", {26'd0, bus.mem_addr}, widx);
    check("mem_read", {31'd0, bus.mem_read}, {31'd0, rd_e});
    check("mem_write", {31'd0, bus.mem_write}, {31'd0, wr_e});
    check("stall", {31'd0, bus.stall}, {31'd0, st_e});

    word = ref_mem[widx];
    case (op)
      MOP_SH:  begin mask = 32'hFFFF << sh; newword = (word & ~mask) | ((wdata & 32'hFFFF) << sh); end
      MOP_SB:  begin mask = 32'hFF << sh;   newword = (word & ~mask) | ((wdata & 32'hFF) << sh); end
      default: newword = wdata;
    endcase
    if (wr_e) check("sw_wd", bus.mem_wd, newword);

    @(posedge clk); #2;
    if (!vld) begin
      check("idle_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      return;
    end
    if (st_e) begin
      check("rmw_stall", {31'd0, bus.stall}, 32'd0);
      check("rmw_write", {31'd0, bus.mem_write}, 32'd1);
      check("rmw_wd", bus.mem_wd, newword);
      check("rmw_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      @(posedge clk); #2;
    end
    if (isst && !exc) ref_mem[widx] = newword;

    case (op)
      MOP_LH:  begin lv = (word >> sh) & 32'hFFFF; if (lv >= 32'h8000) lv = lv | 32'hFFFF0000; end
      MOP_LHU: lv = (word >> sh) & 32'hFFFF;
      MOP_LB:  begin lv = (word >> sh) & 32'hFF; if (lv >= 32'h80) lv = lv | 32'hFFFFFF00; end
      MOP_LBU: lv = (word >> sh) & 32'hFF;
      default: lv = word;
    endcase

    check("wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("wb_rd", {27'd0, bus.wb_rd}, {27'd0, rd});
    check("wb_exc", {31'd0, bus.wb_exc}, {31'd0, exc});
    check("wb_regwrite", {31'd0, bus.wb_regwrite}, {31'd0, (!exc && !isst) ? rw : 1'b0});
    if (isld && !exc)       check("wb_load", bus.wb_data, lv);
    else if (!isld && !isst) check("wb_pass", bus.wb_data, addr);
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, "_valid"}, {31'd0, bus.wb_valid}, 32'd0);
    check({tag, "_data"}, bus.wb_data, 32'd0);
    check({tag, "_rd"}, {27'd0, bus.wb_rd}, 32'd0);
    check({tag, "_regwrite"}, {31'd0, bus.wb_regwrite}, 32'd0);
    check({tag, "_exc"}, {31'd0, bus.wb_exc}, 32'd0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] raddr;
    rst = 1'b1; load_mem = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_op = 4'd0; bus.ex_addr = 32'd0;
    bus.ex_wdata = 32'd0; bus.ex_rd = 5'd0; bus.ex_regwrite = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i);
    @(posedge clk); #2;
    load_mem = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_wb_zero("reset_wb");
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    check("reset_mem_write", {31'd0, bus.mem_write}, 32'd0);
    check("reset_mem_read", {31'd0, bus.mem_read}, 32'd0);
    @(posedge clk); #2;

    // Directed scenarios on a freshly loaded memory.
    do_op(MOP_LW,  32'h14, 32'h0,        5'd3, 1'b1, 1'b1);
    do_op(MOP_SB,  32'h09, 32'h000000AB, 5'd4, 1'b1, 1'b1);
    check("tp_sb_mem2", dmem[2], 32'h0000AB02);
    do_op(MOP_LW,  32'h08, 32'h0,        5'd5, 1'b1, 1'b1);
    do_op(MOP_LB,  32'h09, 32'h0,        5'd6, 1'b1, 1'b1);
    do_op(MOP_LBU, 32'h09, 32'h0,        5'd7, 1'b1, 1'b1);
    do_op(MOP_SH,  32'h0E, 32'h00008001, 5'd8, 1'b0, 1'b1);
    check("tp_sh_mem3", dmem[3], 32'h80010003);
    do_op(MOP_LH,  32'h0E, 32'h0,        5'd9, 1'b1, 1'b1);
    do_op(MOP_LHU, 32'h0E, 32'h0,        5'd10, 1'b1, 1'b1);
    do_op(MOP_LW,  32'h06, 32'h0,        5'd11, 1'b1, 1'b1);
    do_op(MOP_SH,  32'h0B, 32'hFFFF,     5'd12, 1'b1, 1'b1);
    check("tp_exc_mem1", dmem[1], 32'h1);
    check("tp_exc_mem2", dmem[2], 32'h0000AB02);
    do_op(MOP_NONE, 32'hDEADBEEF, 32'h0, 5'd13, 1'b1, 1'b1);
    do_op(4'd12,   32'h12345678, 32'h0,  5'd14, 1'b1, 1'b1);
    do_op(MOP_LW,  32'h00000400, 32'h0,  5'd15, 1'b1, 1'b1);

    // Randomized mix including idle cycles, out-of-range and unknown ops.
    for (int n = 0; n < 400; n++) begin
      rop   = 4'($urandom_range(0, 11));
      raddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      do_op(rop, raddr, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) != 0);
    end

    // Reset during the write cycle of a byte store must abort it.
    bus.ex_valid = 1'b1; bus.ex_op = MOP_SB; bus.ex_addr = 32'h10;
    bus.ex_wdata = 32'h55; bus.ex_rd = 5'd1; bus.ex_regwrite = 1'b0;
    @(posedge clk); #2;
    check("abort_pre_write", {31'd0, bus.mem_write}, 32'd1);
    rst = 1'b1; bus.ex_valid = 1'b0;
    #1;
    check("abort_write", {31'd0, bus.mem_write}, 32'd0);
    check("abort_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("abort_mem4", dmem[4], ref_mem[4]);
    check_wb_zero("abort_wb");
    @(posedge clk); #2;
    do_op(MOP_LW, 32'h10, 32'h0, 5'd2, 1'b1, 1'b1);

    for (int i = 0; i < 64; i++) check("final_mem", dmem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage access controller between the EX/MEM pipeline register and the 64x32 word-addressed data memory.
- Converts byte addresses to word indices and performs sign/zero extension for LB/LBU/LH/LHU/LW.
- Performs SB/SH as a two-cycle read-modify-write, stalling upstream for the extra cycle, and flags misaligned accesses.
- Drives the MEM/WB register outputs (wb_*) consumed by writeback.

Parameters:
- ADDR_W, 6: memory word-address width; the memory has 2**ADDR_W words.
- DATA_W, 32: data width; fixed, other values unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_op  in  4  memory op code (package enum)
- ex_addr  in  32  byte address, or ALU result when op=MOP_NONE
- ex_wdata  in  32  store data (rt)
- ex_rd  in  5  destination register
- ex_regwrite  in  1  instruction writes a register
- stall  out  1  upstream must hold all ex_* stable and not advance
- mem_addr  out  ADDR_W  word index to memory = ex_addr[ADDR_W+1:2]
- mem_wd  out  32  write data to memory
- mem_write  out  1  memory write enable (sampled at posedge)
- mem_read  out  1  memory read enable
- mem_rd  in  32  combinational memory read data
- wb_valid  out  1  MEM/WB holds a retired instruction
- wb_data  out  32  load result or passed-through ALU result
- wb_rd  out  5  destination register
- wb_regwrite  out  1  writeback enable
- wb_exc  out  1  address exception on this retirement

Behaviour:
- Reset: state=IDLE; all wb_* =0; stall=0; mem_write=0; mem_read=0; the merge register clears to 0.
- Endianness is little: byte lane n = bits [8n+7:8n], selected by ex_addr[1:0].
- Exception condition:
  - LW/SW with ex_addr[1:0]!=0, LH/LHU/SH with ex_addr[0]!=0, or any memory op with ex_addr[31:ADDR_W+2]!=0.
  - Effect: mem_read=0, mem_write=0, wb_exc=1, wb_regwrite=0, no stall.
- IDLE, ex_valid=0: wb_valid<=0, no memory access.
- IDLE, MOP_NONE: wb_data<=ex_addr; wb_regwrite<=ex_regwrite; latency 1.
- IDLE, load:
  - mem_read=1 combinationally.
  - At posedge: wb_data<=extract/extend(mem_rd); wb_regwrite<=ex_regwrite; latency 1.
- IDLE, SW: mem_write=1 and mem_wd=ex_wdata in the same cycle; retires at that edge with wb_regwrite=0.
- IDLE, SB/SH:
  - Cycle 1: mem_read=1, stall=1; at posedge capture mem_rd into rmw_q; state<=WRITE; wb_valid<=0.
- WRITE state:
  - mem_write=1, stall=0; mem_wd=rmw_q with the selected byte/halfword lanes replaced by ex_wdata[7:0]/[15:0].
  - At posedge: state<=IDLE, wb_valid<=1, wb_regwrite<=0.
  - ex_* inputs are guaranteed stable in this state because stall was asserted.
- Store-then-load back-to-back to the same word: the load sees the new data, since the memory write lands at the edge before the load's read.
- wb_rd<=ex_rd on every retirement; wb_exc<=0 on every non-exception retirement.
- Reset asserted in WRITE: the state aborts immediately to IDLE; no memory write occurs; stall drops asynchronously.
- Unknown op code: treated as MOP_NONE with wb_exc=1 and wb_regwrite=0.

Decomposition:
- Package mem_access_pkg:
  - mop_t enum: MOP_NONE=0, MOP_LW, MOP_LH, MOP_LHU, MOP_LB, MOP_LBU, MOP_SW, MOP_SH, MOP_SB.
  - State encoding: IDLE=0, WRITE=1.
  - Helper functions: is_load, is_store, is_subword.
- Sub-module mem_lane_align (combinational):
  - Load extract/sign-extend path.
  - Store merge path.
  - Reused by both the load and RMW paths.

Test Plan (memory holds memory[i]=i after reset):
- LW ex_addr=0x14 -> mem_addr=5; next cycle wb_valid=1, wb_data=0x00000005, wb_regwrite=1.
- SB ex_addr=0x09, wdata=0x000000AB -> stall=1 for one cycle, then mem_write with mem_wd=0x0000AB02; a following LW 0x08 returns 0x0000AB02.
- After the SB, LB 0x09 -> wb_data=0xFFFFFFAB; LBU 0x09 -> wb_data=0x000000AB.
- SH ex_addr=0x0E, wdata=0x00008001 -> memory[3]=0x80010003; LH 0x0E -> 0xFFFF8001; LHU 0x0E -> 0x00008001.
- LW 0x06 and SH 0x0B -> wb_exc=1, wb_regwrite=0, mem_read=0, mem_write=0, stall=0; memory[1] and memory[2] unchanged.
- SB 0x10 with rst pulsed during the WRITE cycle -> no write; memory[4]=4; state IDLE; all wb_* =0.
